// File: rtl/uart_tx_seq_if.sv
// uart_tx_seq_if: RAM read port and UART transmit handshake driven by the sequencer
interface uart_tx_seq_if #(parameter int ADDR_W = 8);
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic [7:0]        tx_data;
    logic              tx_send_en;
    logic              tx_done;
    logic              tx_busy;
    modport master(output rd_en, rd_addr, tx_data, tx_send_en, input rd_data, tx_done, tx_busy);
    modport slave(input rd_en, rd_addr, tx_data, tx_send_en, output rd_data, tx_done, tx_busy);
endinterface

// File: rtl/uart_tx_seq.sv
// uart_tx_seq: streams a block of RAM bytes into a UART transmitter, with abort, watchdog and status
module uart_tx_seq #(
    parameter int ADDR_W  = 8,
    parameter int GAP_CYC = 2,
    parameter int TIMEOUT = 100000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W-1:0] start_addr,
    input  logic [ADDR_W:0]   length,
    input  logic              abort,
    uart_tx_seq_if.master     bus,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [ADDR_W:0]   sent_cnt
);
    localparam int TW = $clog2(TIMEOUT + 1);
    typedef enum logic [2:0] {IDLE, READ, LATCH, SEND, WAIT_DONE, GAP, FINISH} state_t;
    state_t          state;
    logic [ADDR_W:0] rem;
    logic [TW-1:0]   cnt;
    logic            abort_q;
    logic            abort_seen;
    assign abort_seen = abort_q | abort;
    // rd_addr doubles as the address pointer; cnt serves both the watchdog and the gap timer
    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            bus.rd_en      <= 1'b0;
            bus.rd_addr    <= '0;
            bus.tx_data    <= '0;
            bus.tx_send_en <= 1'b0;
            busy           <= 1'b0;
            done           <= 1'b0;
            err            <= 1'b0;
            sent_cnt       <= '0;
            rem            <= '0;
            cnt            <= '0;
            abort_q        <= 1'b0;
        end else begin
            bus.rd_en      <= 1'b0;
            bus.tx_send_en <= 1'b0;
            done           <= 1'b0;
            abort_q        <= (state == IDLE) ? (start & abort) : (abort_q | abort);
            case (state)
                IDLE: if (start) begin
                    bus.rd_addr <= start_addr;
                    rem         <= length;
                    sent_cnt    <= '0;
                    err         <= 1'b0;
                    busy        <= 1'b1;
                    bus.rd_en   <= (length != '0);
                    state       <= (length == '0) ? FINISH : READ;
                end
                READ: state <= abort_seen ? FINISH : LATCH;
                LATCH, SEND: begin
                    if (state == LATCH) bus.tx_data <= bus.rd_data;
                    if (abort_seen) state <= FINISH;
                    else if (!bus.tx_busy) begin
                        bus.tx_send_en <= 1'b1;
                        rem            <= rem - 1'b1;
                        bus.rd_addr    <= bus.rd_addr + 1'b1;
                        cnt            <= '0;
                        state          <= WAIT_DONE;
                    end else state <= SEND;
                end
                WAIT_DONE: if (bus.tx_done) begin
                    sent_cnt <= sent_cnt + 1'b1;
                    cnt      <= '0;
                    if (rem == '0 || abort_seen) state <= FINISH;
                    else if (GAP_CYC == 0) begin
                        state     <= READ;
                        bus.rd_en <= 1'b1;
                    end else state <= GAP;
                end else if (cnt == TW'(TIMEOUT - 1)) begin
                    err   <= 1'b1;
                    state <= FINISH;
                end else cnt <= cnt + 1'b1;
                GAP: if (abort_seen) state <= FINISH;
                else if (cnt == TW'(GAP_CYC - 1)) begin
                    state     <= READ;
                    bus.rd_en <= 1'b1;
                end else cnt <= cnt + 1'b1;
                FINISH: begin
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_uart_tx_seq.sv
// tb_uart_tx_seq: directed tests of the RAM-to-UART sequencer with a RAM and UART model
module tb_uart_tx_seq;
    logic clk = 0, rst = 1, start = 0, abort = 0;
    logic [7:0] start_addr = 0;
    logic [8:0] length = 0;
    logic busy, done, err;
    logic [8:0] sent_cnt;
    int cyc = 0, pass_cnt = 0, tot_cnt = 0, done_dly = 20, cd = 0, cs = 0;
    logic err_prev = 0;
    logic [7:0] ram [256];
    int rd_cyc[$], rd_adr[$], se_cyc[$], se_dat[$], td_cyc[$], dn_cyc[$], er_cyc[$];

    uart_tx_seq_if #(.ADDR_W(8)) bus ();
    uart_tx_seq #(.ADDR_W(8), .GAP_CYC(2), .TIMEOUT(50)) dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr), .length(length),
        .abort(abort), .bus(bus), .busy(busy), .done(done), .err(err), .sent_cnt(sent_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    always @(posedge clk) if (bus.rd_en) bus.rd_data <= ram[bus.rd_addr];

    // UART model: tx_done pulses done_dly cycles after each send_en (never when done_dly is 0)
    always @(negedge clk) begin
        bus.tx_done = 1'b0;
        if (cd != 0) begin
            cd = cd - 1;
            if (cd == 0) begin
                bus.tx_done = 1'b1;
                td_cyc.push_back(cyc);
            end
        end
        if (bus.tx_send_en && done_dly != 0) cd = done_dly;
    end

    always @(negedge clk) begin
        if (bus.rd_en) begin
            rd_cyc.push_back(cyc);
            rd_adr.push_back(int'(bus.rd_addr));
        end
        if (bus.tx_send_en) begin
            se_cyc.push_back(cyc);
            se_dat.push_back(int'(bus.tx_data));
        end
        if (done) dn_cyc.push_back(cyc);
        if (err && !err_prev) er_cyc.push_back(cyc);
        err_prev = err;
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_logs;
        rd_cyc.delete(); rd_adr.delete(); se_cyc.delete(); se_dat.delete();
        td_cyc.delete(); dn_cyc.delete(); er_cyc.delete();
    endtask

    task automatic do_start(input logic [7:0] a, input logic [8:0] n);
        @(negedge clk);
        start = 1; start_addr = a; length = n; cs = cyc;
        @(negedge clk);
        start = 0;
    endtask

    task automatic wait_done(input int max);
        for (int i = 0; i < max && dn_cyc.size() == 0; i++) @(negedge clk);
        tot_cnt++; if (dn_cyc.size() == 0) $display("FAIL wait_done: got no done pulse, want one within %0d cycles", max); else pass_cnt++;
        tick(2);
    endtask

    task automatic wait_se(input int n, input int max);
        for (int i = 0; i < max && se_cyc.size() < n; i++) @(negedge clk);
        tot_cnt++; if (se_cyc.size() < n) $display("FAIL wait_se: got %0d send_en, want %0d", se_cyc.size(), n); else pass_cnt++;
    endtask

    task automatic test_reset;
        rst = 1; tick(3);
        tot_cnt++; if ({bus.rd_en, bus.tx_send_en, busy, done, err} !== 5'b0) $display("FAIL reset_ctrl: got %b want 00000", {bus.rd_en, bus.tx_send_en, busy, done, err}); else pass_cnt++;
        tot_cnt++; if ({bus.rd_addr, bus.tx_data} !== 16'h0) $display("FAIL reset_data: got %h want 0000", {bus.rd_addr, bus.tx_data}); else pass_cnt++;
        tot_cnt++; if (sent_cnt !== 9'd0) $display("FAIL reset_cnt: got %0d want 0", sent_cnt); else pass_cnt++;
        rst = 0;
    endtask

    task automatic test_nominal;
        logic [7:0] exp_d [4] = '{8'hA5, 8'h3C, 8'hFF, 8'h00};
        for (int i = 0; i < 4; i++) ram[8'h10 + i] = exp_d[i];
        done_dly = 20; clear_logs();
        do_start(8'h10, 9'd4);
        wait_done(400);
        tot_cnt++; if (se_cyc.size() !== 4) $display("FAIL nom_send_count: got %0d want 4", se_cyc.size()); else pass_cnt++;
        tot_cnt++; if (rd_cyc[0] - cs !== 1) $display("FAIL nom_start_to_rd: got %0d want 1", rd_cyc[0] - cs); else pass_cnt++;
        for (int i = 0; i < 4; i++) begin
            tot_cnt++; if (se_dat[i] !== int'(exp_d[i])) $display("FAIL nom_data[%0d]: got %h want %h", i, se_dat[i], exp_d[i]); else pass_cnt++;
            tot_cnt++; if (rd_adr[i] !== 'h10 + i) $display("FAIL nom_addr[%0d]: got %h want %h", i, rd_adr[i], 'h10 + i); else pass_cnt++;
            tot_cnt++; if (se_cyc[i] - rd_cyc[i] !== 2) $display("FAIL nom_rd_to_send[%0d]: got %0d want 2", i, se_cyc[i] - rd_cyc[i]); else pass_cnt++;
        end
        for (int i = 0; i < 3; i++) begin
            tot_cnt++; if (rd_cyc[i + 1] - td_cyc[i] !== 3) $display("FAIL nom_gap[%0d]: got %0d want 3", i, rd_cyc[i + 1] - td_cyc[i]); else pass_cnt++;
        end
        tot_cnt++; if (dn_cyc.size() !== 1) $display("FAIL nom_done_count: got %0d want 1", dn_cyc.size()); else pass_cnt++;
        tot_cnt++; if (dn_cyc[0] - td_cyc[3] !== 2) $display("FAIL nom_done_lat: got %0d want 2", dn_cyc[0] - td_cyc[3]); else pass_cnt++;
        tot_cnt++; if ({sent_cnt, err, busy} !== {9'd4, 2'b00}) $display("FAIL nom_status: got %0d/%b/%b want 4/0/0", sent_cnt, err, busy); else pass_cnt++;
    endtask

    task automatic test_zero_wrap;
        logic [7:0] exp_d [3] = '{8'h11, 8'h22, 8'h33};
        int exp_a [3] = '{'hFE, 'hFF, 'h00};
        clear_logs();
        do_start(8'h40, 9'd0);
        wait_done(20);
        tot_cnt++; if (dn_cyc[0] - cs !== 2) $display("FAIL zero_done_lat: got %0d want 2", dn_cyc[0] - cs); else pass_cnt++;
        tot_cnt++; if (rd_cyc.size() + se_cyc.size() !== 0) $display("FAIL zero_activity: got %0d strobes want 0", rd_cyc.size() + se_cyc.size()); else pass_cnt++;
        for (int i = 0; i < 3; i++) ram[exp_a[i]] = exp_d[i];
        clear_logs();
        do_start(8'hFE, 9'd3);
        wait_done(400);
        for (int i = 0; i < 3; i++) begin
            tot_cnt++; if (rd_adr[i] !== exp_a[i]) $display("FAIL wrap_addr[%0d]: got %h want %h", i, rd_adr[i], exp_a[i]); else pass_cnt++;
            tot_cnt++; if (se_dat[i] !== int'(exp_d[i])) $display("FAIL wrap_data[%0d]: got %h want %h", i, se_dat[i], exp_d[i]); else pass_cnt++;
        end
        tot_cnt++; if (sent_cnt !== 9'd3) $display("FAIL wrap_cnt: got %0d want 3", sent_cnt); else pass_cnt++;
    endtask

    task automatic test_abort;
        for (int i = 0; i < 8; i++) ram[8'h20 + i] = 8'h80 + 8'(i);
        clear_logs();
        do_start(8'h20, 9'd8);
        wait_se(3, 300);
        tick(5);
        abort = 1; tick(1); abort = 0;
        wait_done(200);
        tick(30);
        tot_cnt++; if (se_cyc.size() !== 3) $display("FAIL abort_sends: got %0d want 3", se_cyc.size()); else pass_cnt++;
        tot_cnt++; if (sent_cnt !== 9'd3) $display("FAIL abort_cnt: got %0d want 3", sent_cnt); else pass_cnt++;
        tot_cnt++; if (dn_cyc.size() !== 1) $display("FAIL abort_done_count: got %0d want 1", dn_cyc.size()); else pass_cnt++;
        tot_cnt++; if (dn_cyc[0] - td_cyc[2] !== 2) $display("FAIL abort_done_lat: got %0d want 2", dn_cyc[0] - td_cyc[2]); else pass_cnt++;
    endtask

    task automatic test_watchdog;
        done_dly = 0; clear_logs();
        do_start(8'h30, 9'd2);
        wait_done(200);
        tot_cnt++; if (se_cyc.size() !== 1) $display("FAIL wd_sends: got %0d want 1", se_cyc.size()); else pass_cnt++;
        tot_cnt++; if (er_cyc[0] - se_cyc[0] !== 50) $display("FAIL wd_err_lat: got %0d want 50", er_cyc[0] - se_cyc[0]); else pass_cnt++;
        tot_cnt++; if (dn_cyc[0] - se_cyc[0] !== 51) $display("FAIL wd_done_lat: got %0d want 51", dn_cyc[0] - se_cyc[0]); else pass_cnt++;
        tot_cnt++; if ({err, sent_cnt} !== {1'b1, 9'd0}) $display("FAIL wd_sticky: got %b/%0d want 1/0", err, sent_cnt); else pass_cnt++;
        done_dly = 20; clear_logs();
        do_start(8'h30, 9'd1);
        tot_cnt++; if ({err, busy} !== 2'b01) $display("FAIL wd_clear: got err/busy %b want 01", {err, busy}); else pass_cnt++;
        wait_done(200);
        tot_cnt++; if ({err, sent_cnt} !== {1'b0, 9'd1}) $display("FAIL wd_retry: got %b/%0d want 0/1", err, sent_cnt); else pass_cnt++;
    endtask

    task automatic test_backpressure;
        int b;
        bus.tx_busy = 1; clear_logs();
        do_start(8'h10, 9'd1);
        tick(9);
        tot_cnt++; if (se_cyc.size() !== 0) $display("FAIL bp_held: got %0d send_en want 0", se_cyc.size()); else pass_cnt++;
        bus.tx_busy = 0; b = cyc;
        wait_done(200);
        tot_cnt++; if (se_cyc[0] !== b + 1) $display("FAIL bp_release: got cycle %0d want %0d", se_cyc[0], b + 1); else pass_cnt++;
        tot_cnt++; if (se_dat[0] !== 'hA5) $display("FAIL bp_data: got %h want a5", se_dat[0]); else pass_cnt++;
        tot_cnt++; if (sent_cnt !== 9'd1) $display("FAIL bp_cnt: got %0d want 1", sent_cnt); else pass_cnt++;
    endtask

    task automatic test_rst_ignored;
        clear_logs();
        do_start(8'h10, 9'd4);
        wait_se(1, 50);
        tick(3);
        rst = 1; tick(1); rst = 0;
        tot_cnt++; if ({bus.rd_en, bus.tx_send_en, busy, done, err} !== 5'b0) $display("FAIL rst_ctrl: got %b want 00000", {bus.rd_en, bus.tx_send_en, busy, done, err}); else pass_cnt++;
        tot_cnt++; if ({bus.rd_addr, bus.tx_data, sent_cnt} !== 25'h0) $display("FAIL rst_data: got %h/%h/%0d want 00/00/0", bus.rd_addr, bus.tx_data, sent_cnt); else pass_cnt++;
        clear_logs();
        tick(30);
        tot_cnt++; if (rd_cyc.size() + se_cyc.size() + dn_cyc.size() !== 0) $display("FAIL rst_quiet: got %0d events want 0", rd_cyc.size() + se_cyc.size() + dn_cyc.size()); else pass_cnt++;
        tot_cnt++; if ({busy, sent_cnt} !== 10'h0) $display("FAIL rst_late_done: got busy %b cnt %0d want 0/0", busy, sent_cnt); else pass_cnt++;
        ram[8'h50] = 8'h5A; ram[8'h51] = 8'hC3;
        clear_logs();
        do_start(8'h50, 9'd2);
        wait_se(1, 50);
        tick(2);
        start = 1; start_addr = 8'h00; length = 9'd8; tick(1); start = 0;
        wait_done(300);
        tick(30);
        tot_cnt++; if (se_cyc.size() !== 2) $display("FAIL ign_sends: got %0d want 2", se_cyc.size()); else pass_cnt++;
        tot_cnt++; if (sent_cnt !== 9'd2) $display("FAIL ign_cnt: got %0d want 2", sent_cnt); else pass_cnt++;
        tot_cnt++; if (rd_adr[1] !== 'h51) $display("FAIL ign_addr: got %h want 51", rd_adr[1]); else pass_cnt++;
        tot_cnt++; if (se_dat[1] !== 'hC3) $display("FAIL ign_data: got %h want c3", se_dat[1]); else pass_cnt++;
    endtask

    initial begin
        bus.tx_busy = 0;
        test_reset();
        test_nominal();
        test_zero_wrap();
        test_abort();
        test_watchdog();
        test_backpressure();
        test_rst_ignored();
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation still running at %0t", $time);
        $fatal(1, "global timeout");
    end
endmodule

// File: doc/uart_tx_seq.md
Name: uart_tx_seq

Overview:
- Sequencer that streams a block of bytes from the dual-port RAM read port into the UART transmitter.
- On a start pulse it reads `length` bytes beginning at `start_addr`, one at a time.
- For each byte it presents the data with a single-cycle send-enable, then waits for the transmitter's done pulse before fetching the next byte.
- Sits between the dpram read port and the UART TX in the dpram loop-back design; provides abort, a per-byte watchdog and completion/error status.

Parameters:
- ADDR_W, 8, RAM address width; addresses wrap modulo 2^ADDR_W.
- GAP_CYC, 2, idle cycles inserted after each tx_done before the next RAM read (0 allowed).
- TIMEOUT, 100000, maximum cycles spent waiting for tx_done per byte; counter width is $clog2(TIMEOUT+1).

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous active-high reset.
- start  in  1  single-cycle pulse; begins a transfer when idle.
- start_addr  in  ADDR_W  first RAM address; sampled with start.
- length  in  ADDR_W+1  byte count, 0..2^ADDR_W; sampled with start.
- abort  in  1  level or pulse; stops the transfer after the in-flight byte.
- rd_en  out  1  RAM read strobe.
- rd_addr  out  ADDR_W  RAM read address.
- rd_data  in  8  RAM read data, valid the cycle after rd_en.
- tx_data  out  8  byte to the UART data input.
- tx_send_en  out  1  one-cycle send-enable to the UART.
- tx_done  in  1  UART one-cycle frame-complete pulse.
- tx_busy  in  1  UART state (high while framing).
- busy  out  1  high from the cycle after start is accepted until done/err.
- done  out  1  one-cycle pulse on successful completion or abort.
- err  out  1  sticky watchdog error; cleared by the next accepted start or by rst.
- sent_cnt  out  ADDR_W+1  bytes completed (tx_done seen) in the current or last transfer.

Behaviour:
- Clock and reset: one clock, clk; reset rst is synchronous, active-high. All outputs are registered.
- Reset values: state=IDLE; rd_en=0, rd_addr=0, tx_data=0, tx_send_en=0, busy=0, done=0, err=0, sent_cnt=0. rst mid-transfer returns to IDLE immediately; no further tx_send_en is issued.
- States: IDLE, READ, LATCH, SEND, WAIT_DONE, GAP, FINISH.
  - IDLE: start=1 latches start_addr into the address pointer and length into the remaining count, clears sent_cnt and err, sets busy.
    - length=0 -> FINISH.
    - Otherwise -> READ.
    - start while not IDLE is ignored.
  - READ: rd_en=1 for exactly one cycle with rd_addr=pointer -> LATCH.
  - LATCH: register rd_data into tx_data -> SEND.
  - SEND: if tx_busy=0, assert tx_send_en for one cycle with tx_data stable, decrement remaining, increment pointer (wraps) -> WAIT_DONE. If tx_busy=1, hold in SEND without asserting tx_send_en.
  - WAIT_DONE: count cycles.
    - tx_done=1: increment sent_cnt. Then go to FINISH if remaining=0 or abort has been seen; otherwise go to GAP, or to READ when GAP_CYC=0.
    - Count reaches TIMEOUT without tx_done: set err=1 -> FINISH.
  - GAP: wait GAP_CYC cycles -> READ. An abort seen here -> FINISH.
  - FINISH: done=1 for one cycle, busy=0 -> IDLE.
- Latency (GAP_CYC=0, tx_busy=0):
  - Start sampled at edge E0: rd_en high after E0, tx_data valid and tx_send_en high after E2.
  - tx_done sampled at edge Ek: next rd_en high after Ek.
  - Last tx_done sampled at Ek: done high after Ek+1.
- abort handling: abort is captured into a sticky flag while busy.
  - In READ, LATCH or SEND before send_en is issued: no send_en; go to FINISH.
  - In WAIT_DONE: the in-flight frame completes (or times out) first.
  - The flag is cleared in IDLE.
- Simultaneous events:
  - start and abort in the same IDLE cycle: start is accepted and the abort flag is set, so no byte is sent and done pulses.
  - tx_done coinciding with the TIMEOUT terminal count: tx_done wins and err stays 0.
- Address wrap: pointer 2^ADDR_W-1 increments to 0. length=2^ADDR_W sends every location once.
- tx_send_en is never asserted twice without an intervening tx_done or timeout.

Test Plan:
- Nominal transfer: RAM[0x10..0x13]=A5,3C,FF,00; start_addr=0x10, length=4; UART model returns tx_done 20 cycles after send_en. Required: tx_data sequence A5,3C,FF,00, each tx_send_en exactly 1 cycle; rd_en→tx_send_en spacing is 2 cycles; rd_addr 10..13; one done pulse; sent_cnt=4; err=0.
- Zero length and wrap: length=0 -> done pulses 2 cycles after start, with no rd_en and no tx_send_en. Then start_addr=0xFE, length=3 -> rd_addr sequence FE,FF,00.
- Abort mid-transfer: length=8, abort asserted during the 3rd WAIT_DONE. Required: the 3rd frame completes, no 4th send_en, done pulses, sent_cnt=3.
- Watchdog: UART model never returns tx_done, TIMEOUT=50. Required: err=1 exactly 50 cycles after send_en, then done; a second start clears err.
- Back-pressure and gap: tx_busy held high for 10 cycles entering SEND -> send_en delayed until tx_busy=0. With GAP_CYC=2, rd_en rises exactly 3 cycles after each tx_done sample.
- Reset and ignored start: rst in WAIT_DONE -> all outputs 0 the next cycle, and a later tx_done is ignored. start pulsed while busy -> ignored, and the transfer length is unchanged.
